hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller that drives the front-end control inputs of the fetch stage and the IF/ID register: `PCWrite`, `IFIDWrite` and `IF_flush`. It also drives the ID/EX bubble and the EX hold. The block detects load-use hazards against the ID-stage instruction and flushes on taken branches resolved in EX. It sequences a multi-cycle mul/div freeze with an internal FSM and down-counter, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `MD_LAT`, default 4: total EX occupancy of a mul/div in cycles. Legal range is 2..15.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `id_rs1` in 5: source register 1 of the instruction in ID.
- `id_rs2` in 5: source register 2 of the instruction in ID.
- `id_use_rs1` in 1: the ID instruction reads rs1.
- `id_use_rs2` in 1: the ID instruction reads rs2.
- `ex_memread` in 1: the EX instruction is a load.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_md_start` in 1: a mul/div is in EX this cycle, first cycle.
- `ex_branch_taken` in 1: a branch or jump resolved taken in EX this cycle.
- `PCWrite` out 1: PC register update enable.
- `IFIDWrite` out 1: IF/ID register update enable.
- `IF_flush` out 1: clears IF/ID to NOP on the next edge.
- `IDEX_flush` out 1: inserts a bubble into ID/EX on the next edge.
- `EX_hold` out 1: freezes EX/MEM input and mul/div operands.
- `md_busy` out 1: the FSM is in MD_BUSY.
- `stall_cycles` out CNT_W: count of cycles with `PCWrite`=0.
- `flush_count` out CNT_W: count of cycles with `IF_flush`=1.

## Operation
- The FSM has two states, RUN and MD_BUSY, plus a 4-bit down-counter `md_cnt`.
- Load-use condition `lu`: `ex_memread` && `ex_rd`!=0 && ((`id_use_rs1` && `id_rs1`==`ex_rd`) || (`id_use_rs2` && `id_rs2`==`ex_rd`)).
- RUN outputs, evaluated in priority order:
  - `ex_branch_taken`: `PCWrite`=1, `IFIDWrite`=1, `IF_flush`=1, `IDEX_flush`=1. This branch ignores `lu` and ignores `ex_md_start`.
  - Otherwise `ex_md_start`: `PCWrite`=0, `IFIDWrite`=0, `EX_hold`=1, `IDEX_flush`=0. Next state is MD_BUSY and `md_cnt` loads MD_LAT-2.
  - Otherwise `lu`: `PCWrite`=0, `IFIDWrite`=0, `IDEX_flush`=1, `IF_flush`=0.
  - Otherwise: `PCWrite`=1, `IFIDWrite`=1, all flush and hold outputs 0.
- MD_BUSY outputs: `PCWrite`=0, `IFIDWrite`=0, `EX_hold`=1, `md_busy`=1, and both flushes 0.
  - `ex_branch_taken`, `ex_md_start` and `lu` are all ignored in MD_BUSY.
  - When `md_cnt`==0 the next state is RUN. Otherwise `md_cnt` decrements.
- The freeze therefore lasts MD_LAT cycles in total, counting the start cycle.
- Counters:
  - `stall_cycles` increments on each edge where `PCWrite`=0.
  - `flush_count` increments on each edge where `IF_flush`=1.
  - Both saturate at all-ones and never wrap.
- Reset:
  - At the next edge: state RUN, `md_cnt`=0, both counters 0.
  - Reset during MD_BUSY aborts the freeze.
  - While `reset`=1, all outputs take their RUN idle values: `PCWrite`=1, `IFIDWrite`=1, `IF_flush`=0, `IDEX_flush`=0, `EX_hold`=0, `md_busy`=0.
- Register x0 never causes a load-use stall.

## Timing
- All control outputs are combinational from state plus the current-cycle inputs. Output latency is 0 cycles.
- The fetch, IF/ID and ID/EX registers act on the same rising edge.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load has left EX and `lu` clears.
- After a taken branch, the next cycle sees the IF/ID contents as NOP.
- MD_BUSY dwell is MD_LAT-1 cycles. `md_busy` rises one cycle after `ex_md_start`.
- Counter outputs are registered: they reflect events up to the previous edge.

## Structure
- Package `hazard_pkg` holds:
  - the state typedef (RUN=1'b0, MD_BUSY=1'b1);
  - the default `MD_LAT`;
  - constant `REG_ZERO`=5'd0.
- One sub-module, `sat_counter`, parameterised by width, with `clk`, `reset` and `inc` inputs. It is instantiated twice.
- The FSM, counter and priority mux are in the top level.

## Test plan
- Load-use stall. Stimulus: `ex_memread`=1, `ex_rd`=5, `id_use_rs1`=1, `id_rs1`=5. Required response: for one cycle `PCWrite`=0, `IFIDWrite`=0, `IDEX_flush`=1; then free run; `stall_cycles` goes 0→1.
- x0 exemption. Stimulus: the same hazard with `ex_rd`=0. Required response: no stall, `PCWrite`=1.
- Branch overrides load-use. Stimulus: `ex_branch_taken`=1 together with the load-use hazard above. Required response: `IF_flush`=1, `IDEX_flush`=1, `PCWrite`=1; `flush_count`=1, `stall_cycles`=0.
- Mul/div freeze with MD_LAT=4. Stimulus: `ex_md_start` pulse. Required response: `PCWrite`=0 for exactly 4 consecutive cycles, `md_busy`=1 for cycles 2-4, then RUN; `stall_cycles`=4. A branch or hazard asserted during MD_BUSY must be ignored.
- Reset mid-freeze. Stimulus: `reset` in the 2nd MD_BUSY cycle. Required response: the next cycle is RUN, `md_busy`=0, counters 0, `PCWrite`=1.
- Saturation with CNT_W=3. Stimulus: hold a stall condition for 10 cycles. Required response: `stall_cycles` stops at 7 and does not wrap.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   state_t   - FSM state encoding (RUN / MD_BUSY)
//   MD_LAT_DEF - default total mul/div EX occupancy in cycles
//   REG_ZERO  - architectural x0, never a load-use source
package hazard_pkg;

    typedef logic [0:0] state_t;

    localparam state_t RUN     = 1'b0;
    localparam state_t MD_BUSY = 1'b1;

    localparam int MD_LAT_DEF = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   master: pipeline side, drives ID/EX status, receives the control outputs
//   slave : hazard controller side
//   ID status : id_rs1, id_rs2, id_use_rs1, id_use_rs2
//   EX status : ex_memread, ex_rd, ex_md_start, ex_branch_taken
//   controls  : PCWrite, IFIDWrite, IF_flush, IDEX_flush, EX_hold, md_busy
interface hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       ex_md_start;
    logic       ex_branch_taken;

    logic       PCWrite;
    logic       IFIDWrite;
    logic       IF_flush;
    logic       IDEX_flush;
    logic       EX_hold;
    logic       md_busy;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_memread, ex_rd, ex_md_start, ex_branch_taken,
        input  PCWrite, IFIDWrite, IF_flush, IDEX_flush, EX_hold, md_busy
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_memread, ex_rd, ex_md_start, ex_branch_taken,
        output PCWrite, IFIDWrite, IF_flush, IDEX_flush, EX_hold, md_busy
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk   - clock
//   reset - synchronous active-high clear
//   inc   - count this edge
//   cnt   - current count (registered)
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: front-end hazard controller.
//   Detects load-use hazards against the ID instruction, flushes IF/ID and
//   ID/EX on a taken branch resolved in EX, and freezes the front end for
//   MD_LAT cycles while a mul/div occupies EX.
//   clk, reset   - clock, synchronous active-high reset
//   hz           - hazard_ctrl_if.slave bundle (pipeline status in, controls out)
//   stall_cycles - saturating count of edges with PCWrite=0
//   flush_count  - saturating count of edges with IF_flush=1
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,  // 2..15
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // The start cycle itself is one freeze cycle, and the busy state exits
    // on the cycle md_cnt reads 0, so loading MD_LAT-2 gives MD_LAT total.
    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 2);

    state_t     state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;

    logic lu;
    logic pc_write, ifid_write, if_flush, idex_flush, ex_hold, busy;

    assign lu = hz.ex_memread && (hz.ex_rd != REG_ZERO) &&
                ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if_flush   = 1'b0;
        idex_flush = 1'b0;
        ex_hold    = 1'b0;
        busy       = 1'b0;

        if (reset) begin
            // idle values while reset is held
            state_nxt  = RUN;
            md_cnt_nxt = '0;
        end else if (state == MD_BUSY) begin
            // all hazard/branch/start inputs ignored while frozen
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_hold    = 1'b1;
            busy       = 1'b1;
            if (md_cnt == '0)
                state_nxt = RUN;
            else
                md_cnt_nxt = md_cnt - 1'b1;
        end else if (hz.ex_branch_taken) begin
            // wrong-path instructions in IF/ID and ID are squashed; the
            // redirect must still load the PC, so no stall here
            if_flush   = 1'b1;
            idex_flush = 1'b1;
        end else if (hz.ex_md_start) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ex_hold    = 1'b1;
            state_nxt  = MD_BUSY;
            md_cnt_nxt = MD_LOAD;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    assign hz.PCWrite    = pc_write;
    assign hz.IFIDWrite  = ifid_write;
    assign hz.IF_flush   = if_flush;
    assign hz.IDEX_flush = idex_flush;
    assign hz.EX_hold    = ex_hold;
    assign hz.md_busy    = busy;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write),
        .cnt   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_flush),
        .cnt   (flush_count)
    );

endmodule
